wb_arbiter: RTL

- Shares the register file's two write ports (dstA/dstB) between three write-back requesters: execute result, memory load, multi-cycle mul/div unit.
- Grants up to two writes per cycle with round-robin fairness.
- Never issues two writes to the same register in one cycle.
- Output is registered and drives the register file's dstA_i/dstA_data_i/dstB_i/dstB_data_i directly.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/wb_arbiter_rr_pick.sv | 45 ++++
 rtl/wb_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the register-file write-back path.
package cpu_pkg;

  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 64;

  // Register id meaning "no write"; the register file ignores it.
  localparam logic [REG_ID_W-1:0] NO_REG = 4'hF;

  // Write-back requester indices.
  localparam int REQ_EXE = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MUL = 2;

  // Round-robin helper: index following i in a ring of n requesters.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Rotating-priority scan. Finds the first valid requester starting at the
// pointer, then the next one after it that is not excluded.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  input  logic [NREQ-1:0] i_excl,
  output logic            o_first_vld,
  output logic [PW-1:0]   o_first_idx,
  output logic            o_second_vld,
  output logic [PW-1:0]   o_second_idx
);

  // First pick: scan backwards so the entry closest to the pointer wins last.
  always_comb begin
    o_first_vld = 1'b0;
    o_first_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_valid[(int'(i_ptr) + k) % NREQ]) begin
        o_first_vld = 1'b1;
        o_first_idx = PW'((int'(i_ptr) + k) % NREQ);
      end
    end
  end

  // Second pick: same scan over the remaining, non-excluded requesters.
  always_comb begin
    logic [NREQ-1:0] w_mask;
    w_mask = i_valid & ~i_excl;
    for (int i = 0; i < NREQ; i++) begin
      if (o_first_vld && (o_first_idx == PW'(i))) w_mask[i] = 1'b0;
    end
    o_second_vld = 1'b0;
    o_second_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_mask[(int'(i_ptr) + k) % NREQ]) begin
        o_second_vld = 1'b1;
        o_second_idx = PW'((int'(i_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: up to two register-file writes per cycle, round-robin,
// never two writes to the same register in one cycle. Outputs are registered.
// Handshake: a transfer happens when valid && ready in the same cycle; the
// requester holds valid/dst/data until accepted, ready may depend on valid.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = DATA_W,
  parameter int RW   = REG_ID_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*RW-1:0] req_dst_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [RW-1:0]      dstA_o,
  output logic [DW-1:0]      dstA_data_o,
  output logic [RW-1:0]      dstB_o,
  output logic [DW-1:0]      dstB_data_o,
  output logic [15:0]        conflict_cnt_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // All-ones id is the "no register" marker (NO_REG at the default width).
  localparam logic [RW-1:0] L_NO_REG = {RW{1'b1}};

  logic [PW-1:0]   r_ptr;
  logic [15:0]     r_cnt;
  logic [RW-1:0]   r_dst_a, r_dst_b;
  logic [DW-1:0]   r_data_a, r_data_b;

  logic [RW-1:0]   w_dst  [NREQ];
  logic [DW-1:0]   w_data [NREQ];
  logic [NREQ-1:0] w_elig, w_discard, w_excl;
  logic            w_first_vld, w_second_vld, w_conflict;
  logic [PW-1:0]   w_first_idx, w_second_idx;
  logic [RW-1:0]   w_dst_first;

  // Unpack requests; split them into port-consuming and discard-only.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_dst[i]     = req_dst_i[i*RW +: RW];
      w_data[i]    = req_data_i[i*DW +: DW];
      w_elig[i]    = req_valid_i[i] && (w_dst[i] != L_NO_REG);
      w_discard[i] = req_valid_i[i] && (w_dst[i] == L_NO_REG);
    end
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_valid      (w_elig),
    .i_ptr        (r_ptr),
    .i_excl       (w_excl),
    .o_first_vld  (w_first_vld),
    .o_first_idx  (w_first_idx),
    .o_second_vld (w_second_vld),
    .o_second_idx (w_second_idx)
  );

  // Port B may not target the register already granted to port A.
  always_comb begin
    w_dst_first = w_dst[w_first_idx];
    for (int i = 0; i < NREQ; i++) begin
      w_excl[i] = (w_dst[i] == w_dst_first);
    end
  end

  // A conflict is a same-register wait seen while port B was still free,
  // i.e. earlier in scan order than the port-B grantee (or with no grantee).
  always_comb begin
    int pos_i, pos_b;
    w_conflict = 1'b0;
    pos_b = (int'(w_second_idx) - int'(r_ptr) + NREQ) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      pos_i = (i - int'(r_ptr) + NREQ) % NREQ;
      if (w_first_vld && w_elig[i] && w_excl[i] && (w_first_idx != PW'(i)) &&
          (!w_second_vld || (pos_i < pos_b))) begin
        w_conflict = 1'b1;
      end
    end
  end

  // Accept discards and granted requesters; nothing is accepted in reset.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = rst_n_i &&
                       (w_discard[i] ||
                        (w_first_vld  && (w_first_idx  == PW'(i))) ||
                        (w_second_vld && (w_second_idx == PW'(i))));
    end
  end

  // Output registers, round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_dst_a  <= L_NO_REG;
      r_dst_b  <= L_NO_REG;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_dst_a  <= w_first_vld  ? w_dst_first          : L_NO_REG;
      r_data_a <= w_first_vld  ? w_data[w_first_idx]  : '0;
      r_dst_b  <= w_second_vld ? w_dst[w_second_idx]  : L_NO_REG;
      r_data_b <= w_second_vld ? w_data[w_second_idx] : '0;
      if (w_second_vld) begin
        r_ptr <= PW'(wrap_inc(int'(w_second_idx), NREQ));
      end else if (w_first_vld) begin
        r_ptr <= PW'(wrap_inc(int'(w_first_idx), NREQ));
      end
      if (w_conflict && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign dstA_o         = r_dst_a;
  assign dstA_data_o    = r_data_a;
  assign dstB_o         = r_dst_b;
  assign dstB_data_o    = r_data_b;
  assign conflict_cnt_o = r_cnt;

endmodule
